// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Data normally wins contention, but after MAXD
// consecutive data grants while a fetch is pending, the fetch is forced through.
//
// Ports
//   clk, reset                 single clock, asynchronous active-high reset
//   ireq/iaddr                 fetch request (held until iready)
//   iready/irdata              one-cycle fetch completion pulse + instruction
//   dreq/dwe/daddr/dwdata      data request (held until dready)
//   dready/drdata              one-cycle data completion pulse + load data
//   stallF/stallM              pipeline stalls for each requester
//   mem_req/mem_we/mem_addr/mem_wdata   shared memory request (held stable)
//   mem_ack/mem_rdata          memory completion + read data
module mem_arbiter #(
  parameter int MAXD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic        iready,
  output logic [31:0] irdata,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        stallF,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  localparam logic [2:0] MAXD3 = 3'(MAXD);

  state_t      state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;

  // A request being acknowledged this cycle must not be granted again.
  logic ielig, delig, d_win;
  assign ielig = ireq & ~iready_q;
  assign delig = dreq & ~dready_q;
  assign d_win = delig & (~ielig | (streak_q < MAXD3));

  // Byte offsets are dropped; memory is word addressed.
  logic unused_lsbs;
  assign unused_lsbs = ^{iaddr[1:0], daddr[1:0]};

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = DACC;
          addr_d  = {daddr[31:2], 2'b00};
          we_d    = dwe;
          wdata_d = dwdata;
          // Streak only counts data grants that starve a waiting fetch.
          if (ireq) streak_d = (streak_q >= MAXD3) ? MAXD3 : streak_q + 3'd1;
          else      streak_d = 3'd0;
        end else if (ielig) begin
          state_d  = IACC;
          addr_d   = {iaddr[31:2], 2'b00};
          we_d     = 1'b0;
          wdata_d  = dwdata;
          streak_d = 3'd0;
        end
      end
      IACC: begin
        if (mem_ack) begin
          state_d  = IDLE;
          irdata_d = mem_rdata;
          iready_d = 1'b1;
        end
      end
      DACC: begin
        if (mem_ack) begin
          state_d  = IDLE;
          drdata_d = mem_rdata;
          dready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 3'd0;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      irdata_q <= 32'h0;
      drdata_q <= 32'h0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign stallF    = ireq & ~iready_q;
  assign stallM    = dreq & ~dready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed tests with a grant/completion scoreboard.
// Expected grants and completions are queued by the stimulus; a negedge
// monitor pops and compares them whenever the DUT issues a memory access or
// a ready pulse.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk, reset;
  logic        ireq, ireq_r, cont_mask;
  logic [31:0] iaddr;
  logic        iready;
  logic [31:0] irdata;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic        dready;
  logic [31:0] drdata;
  logic        stallF, stallM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        rd_fixed_en;
  logic [31:0] rd_fixed;
  int          wait_cfg, wcnt;
  logic        ack_man, ack_force;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } grant_t;
  typedef struct { logic is_d; logic [31:0] data; } compl_t;
  grant_t gq[$];
  compl_t cq[$];

  // Fetch can be masked during a data ready pulse so both requesters meet in IDLE.
  assign ireq = ireq_r & ~(cont_mask & dready);
  assign mem_rdata = rd_fixed_en ? rd_fixed : (mem_addr ^ K);

  mem_arbiter #(.MAXD(4)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iready(iready), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata),
    .stallF(stallF), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic [31:0] a, input logic w, input logic [31:0] d);
    grant_t g;
    g.addr = a; g.we = w; g.wd = d;
    gq.push_back(g);
  endtask

  task automatic push_c(input logic isd, input logic [31:0] d);
    compl_t c;
    c.is_d = isd; c.data = d;
    cq.push_back(c);
  endtask

  // Memory responder: ack after wait_cfg wait cycles, or forced value.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (ack_man) begin
      mem_ack = ack_force;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor
  logic   in_acc = 1'b0;
  grant_t cur;
  compl_t ce;
  always @(negedge clk) begin
    if (reset) begin
      in_acc = 1'b0;
    end else begin
      if (mem_req) begin
        if (!in_acc) begin
          if (gq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_grant actual addr=%h required none", mem_addr);
            cur.addr = mem_addr; cur.we = mem_we; cur.wd = mem_wdata;
          end else cur = gq.pop_front();
          in_acc = 1'b1;
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
        chk("mem_wdata", mem_wdata, cur.wd);
      end else in_acc = 1'b0;
      if (iready || dready) begin
        if (cq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready actual iready=%b dready=%b required none", iready, dready);
        end else begin
          ce = cq.pop_front();
          chk("ready_kind", {30'b0, iready, dready}, {30'b0, ~ce.is_d, ce.is_d});
          chk("rdata", ce.is_d ? drdata : irdata, ce.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ir, n_rise, bound;
    logic prev;
    reset = 1'b1; ireq_r = 0; cont_mask = 0; iaddr = 0; dreq = 0; dwe = 0;
    daddr = 0; dwdata = 0; rd_fixed_en = 0; rd_fixed = 0; wait_cfg = 0;
    ack_man = 0; ack_force = 0;
    cyc();
    @(negedge clk);
    chk("rst_iready", {31'b0, iready}, 32'h0);
    chk("rst_dready", {31'b0, dready}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_irdata", irdata, 32'h0);
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    cyc();
    reset = 1'b0;

    // Zero-wait fetch
    cyc();
    rd_fixed_en = 1; rd_fixed = 32'h2002_0005; wait_cfg = 0;
    ireq_r = 1; iaddr = 32'h4;
    push_g(32'h4, 1'b0, 32'h0); push_c(1'b0, 32'h2002_0005);
    @(negedge clk);
    chk("f_c0_stallF", {31'b0, stallF}, 32'h1);
    chk("f_c0_mem_req", {31'b0, mem_req}, 32'h0);
    cyc(); @(negedge clk);
    chk("f_c1_stallF", {31'b0, stallF}, 32'h1);
    chk("f_c1_mem_req", {31'b0, mem_req}, 32'h1);
    cyc(); @(negedge clk);
    chk("f_c2_iready", {31'b0, iready}, 32'h1);
    chk("f_c2_irdata", irdata, 32'h2002_0005);
    chk("f_c2_stallF", {31'b0, stallF}, 32'h0);
    cyc(); ireq_r = 0; @(negedge clk);
    chk("f_c3_iready", {31'b0, iready}, 32'h0);
    chk("f_c3_mem_req", {31'b0, mem_req}, 32'h0);
    rd_fixed_en = 0;

    // Store with two wait states
    cyc();
    wait_cfg = 2; dreq = 1; dwe = 1; daddr = 32'h54; dwdata = 32'h7;
    push_g(32'h54, 1'b1, 32'h7); push_c(1'b1, 32'h54 ^ K);
    @(negedge clk);
    chk("s_c0_stallM", {31'b0, stallM}, 32'h1);
    chk("s_c0_mem_req", {31'b0, mem_req}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); @(negedge clk);
      chk("s_acc_mem_req", {31'b0, mem_req}, 32'h1);
      chk("s_acc_dready", {31'b0, dready}, 32'h0);
      chk("s_acc_stallM", {31'b0, stallM}, 32'h1);
    end
    cyc(); @(negedge clk);
    chk("s_c4_dready", {31'b0, dready}, 32'h1);
    chk("s_c4_stallM", {31'b0, stallM}, 32'h0);
    cyc(); dreq = 0; dwe = 0; @(negedge clk);
    chk("s_c5_dready", {31'b0, dready}, 32'h0);

    // Misaligned load
    cyc();
    wait_cfg = 0; dreq = 1; daddr = 32'h57; dwdata = 32'h0;
    push_g(32'h54, 1'b0, 32'h0); push_c(1'b1, 32'h54 ^ K);
    cyc(); @(negedge clk);
    chk("mis_mem_addr", mem_addr, 32'h54);
    cyc(); @(negedge clk);
    chk("mis_dready", {31'b0, dready}, 32'h1);
    chk("mis_drdata", drdata, 32'h54 ^ K);
    cyc(); dreq = 0;

    // Fetch withdrawn during the access
    cyc();
    wait_cfg = 3; ireq_r = 1; iaddr = 32'h100;
    push_g(32'h100, 1'b0, 32'h0); push_c(1'b0, 32'h100 ^ K);
    n_ir = 0; n_rise = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (iready) n_ir++;
      if (mem_req && !prev) n_rise++;
      prev = mem_req;
      cyc();
      if (i == 0) ireq_r = 0;
    end
    chk("wd_iready_pulses", n_ir, 32'd1);
    chk("wd_grants", n_rise, 32'd1);

    // Reset in the middle of a data access
    wait_cfg = 0; ack_man = 1; ack_force = 0;
    dreq = 1; dwe = 0; daddr = 32'h20;
    push_g(32'h20, 1'b0, 32'h0);
    cyc(); @(negedge clk);
    chk("rm_mem_req", {31'b0, mem_req}, 32'h1);
    cyc(); #2 reset = 1; dreq = 0;
    @(negedge clk);
    chk("rm_mem_req_rst", {31'b0, mem_req}, 32'h0);
    chk("rm_dready_rst", {31'b0, dready}, 32'h0);
    chk("rm_drdata_rst", drdata, 32'h0);
    chk("rm_mem_addr_rst", mem_addr, 32'h0);
    cyc(); reset = 0; ack_force = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rm_dready_after", {31'b0, dready}, 32'h0);
      chk("rm_mem_req_after", {31'b0, mem_req}, 32'h0);
      cyc();
    end
    ack_man = 0; ack_force = 0;
    // First grant after release happens at the next edge
    ireq_r = 1; iaddr = 32'h8;
    push_g(32'h8, 1'b0, 32'h0); push_c(1'b0, 32'h8 ^ K);
    @(negedge clk);
    chk("rr_c0_mem_req", {31'b0, mem_req}, 32'h0);
    cyc(); @(negedge clk);
    chk("rr_c1_mem_req", {31'b0, mem_req}, 32'h1);
    cyc(); @(negedge clk);
    chk("rr_c2_iready", {31'b0, iready}, 32'h1);
    cyc(); ireq_r = 0;

    // Contention: expect D,D,D,D,I,D,D,D,D,I
    cyc();
    cont_mask = 1; dwdata = 32'h11; iaddr = 32'h200; daddr = 32'h300; dwe = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_g(32'h300, 1'b0, 32'h11); push_c(1'b1, 32'h300 ^ K);
      end
      push_g(32'h200, 1'b0, 32'h11); push_c(1'b0, 32'h200 ^ K);
    end
    ireq_r = 1; dreq = 1;
    bound = 0;
    while (cq.size() > 1 && bound < 300) begin
      @(negedge clk); #1;
      bound++;
    end
    chk("ct_wait1_timeout", {31'b0, bound >= 300}, 32'h0);
    cyc(); dreq = 0;
    bound = 0;
    while (cq.size() > 0 && bound < 100) begin
      @(negedge clk); #1;
      bound++;
    end
    chk("ct_wait2_timeout", {31'b0, bound >= 100}, 32'h0);
    cyc(); ireq_r = 0; cont_mask = 0;

    for (int i = 0; i < 5; i++) cyc();
    chk("grant_q_empty", gq.size(), 32'd0);
    chk("compl_q_empty", cq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
